// File: rtl/draw_pkg.sv
// rtl/draw_pkg.sv - shared state encodings, pixel widths and screen limits for the draw sequencer
package draw_pkg;

  localparam int X_W          = 8;
  localparam int Y_W          = 7;
  localparam int COLOUR_W     = 3;
  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_BG   = 3'd1,
    ST_OBJ  = 3'd2,
    ST_GO   = 3'd3,
    ST_HOLD = 3'd4
  } state_t;

  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
  } pixel_t;

  // x==w shows up while a client wraps to the next row, so the bound is strict
  function automatic logic pixel_on_screen(input pixel_t p, input int w, input int h);
    return (32'(p.x) < 32'(w)) && (32'(p.y) < 32'(h));
  endfunction

endpackage

// File: rtl/draw_sequencer_if.sv
// rtl/draw_sequencer_if.sv - client enable/done/pixel bundle plus the VGA pixel-write port
interface draw_sequencer_if;
  import draw_pkg::*;

  logic                bg_en;
  logic                bg_done;
  logic [X_W-1:0]      bg_x;
  logic [Y_W-1:0]      bg_y;
  logic [COLOUR_W-1:0] bg_colour;

  logic                obj_en;
  logic                obj_done;
  logic [X_W-1:0]      obj_x;
  logic [Y_W-1:0]      obj_y;
  logic [COLOUR_W-1:0] obj_colour;

  logic                go_en;
  logic                go_done;
  logic [X_W-1:0]      go_x;
  logic [Y_W-1:0]      go_y;
  logic [COLOUR_W-1:0] go_colour;

  logic [X_W-1:0]      vga_x;
  logic [Y_W-1:0]      vga_y;
  logic [COLOUR_W-1:0] vga_colour;
  logic                vga_plot;
  logic                frame_start;

  modport master (
    output bg_en, obj_en, go_en,
    output vga_x, vga_y, vga_colour, vga_plot, frame_start,
    input  bg_done, bg_x, bg_y, bg_colour,
    input  obj_done, obj_x, obj_y, obj_colour,
    input  go_done, go_x, go_y, go_colour
  );

  modport slave (
    input  bg_en, obj_en, go_en,
    input  vga_x, vga_y, vga_colour, vga_plot, frame_start,
    output bg_done, bg_x, bg_y, bg_colour,
    output obj_done, obj_x, obj_y, obj_colour,
    output go_done, go_x, go_y, go_colour
  );

endinterface

// File: rtl/frame_tick_gen.sv
// rtl/frame_tick_gen.sv - frame period counter with one-deep pending flag (optional overrun count: DRAW_SEQ_OVERRUN_EN)
module frame_tick_gen #(
  parameter int FRAME_TICKS = 833333
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        clear_pending,
  output logic        pending
`ifdef DRAW_SEQ_OVERRUN_EN
  ,
  output logic [15:0] overrun_cnt
`endif
);

  localparam int CNT_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_TICKS - 1);

  logic [CNT_W-1:0] count;
  logic             tick;

  assign tick = (count == LAST);

  // free-running frame counter, wraps on the tick cycle
  always_ff @(posedge clock) begin
    if (!resetn) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // a tick landing on the consume cycle refills the slot rather than being lost
  always_ff @(posedge clock) begin
    if (!resetn) begin
      pending <= 1'b0;
    end else begin
      pending <= tick | (pending & ~clear_pending);
    end
  end

`ifdef DRAW_SEQ_OVERRUN_EN
  // count ticks that find the slot still full: a frame missed its deadline
  always_ff @(posedge clock) begin
    if (!resetn) begin
      overrun_cnt <= '0;
    end else if (tick && pending && !clear_pending && (overrun_cnt != 16'hFFFF)) begin
      overrun_cnt <= overrun_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: rtl/draw_sequencer.sv
// rtl/draw_sequencer.sv - per-frame BG/OBJ/GO client sequencer with registered VGA pixel port (option: DRAW_SEQ_OVERRUN_EN)
module draw_sequencer
  import draw_pkg::*;
#(
  parameter int FRAME_TICKS = 833333,
  parameter int SCREEN_W    = SCREEN_W_DEF,
  parameter int SCREEN_H    = SCREEN_H_DEF
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        game_over,
  input  logic        restart,
  draw_sequencer_if.master bus
`ifdef DRAW_SEQ_OVERRUN_EN
  ,
  output logic [15:0] overrun_cnt
`endif
);

  state_t state;
  state_t state_next;
  logic   pending;
  logic   clear_pending;
  logic   frame_start_c;

  pixel_t sel_pix;
  logic   sel_active;
  logic   sel_done;

  pixel_t vga_pix_q;
  logic   vga_plot_q;

  frame_tick_gen #(
    .FRAME_TICKS(FRAME_TICKS)
  ) u_tick (
    .clock        (clock),
    .resetn       (resetn),
    .clear_pending(clear_pending),
    .pending      (pending)
`ifdef DRAW_SEQ_OVERRUN_EN
    ,
    .overrun_cnt  (overrun_cnt)
`endif
  );

  // state register; reset aborts whichever client is running
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // next state, frame start and pending consume; game_over only matters at the IDLE decision
  always_comb begin
    state_next    = state;
    clear_pending = 1'b0;
    frame_start_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pending) begin
          clear_pending = 1'b1;
          frame_start_c = 1'b1;
          state_next    = game_over ? ST_GO : ST_BG;
        end
      end
      ST_BG:   if (bus.bg_done)  state_next = ST_OBJ;
      ST_OBJ:  if (bus.obj_done) state_next = ST_IDLE;
      ST_GO:   if (bus.go_done)  state_next = ST_HOLD;
      ST_HOLD: if (restart)      state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.bg_en       = (state == ST_BG);
  assign bus.obj_en      = (state == ST_OBJ);
  assign bus.go_en       = (state == ST_GO);
  assign bus.frame_start = frame_start_c;

  // select the active client's pixel and done; other clients' dones are ignored
  always_comb begin
    sel_pix    = '0;
    sel_active = 1'b0;
    sel_done   = 1'b0;
    case (state)
      ST_BG: begin
        sel_pix    = '{x: bus.bg_x, y: bus.bg_y, colour: bus.bg_colour};
        sel_active = 1'b1;
        sel_done   = bus.bg_done;
      end
      ST_OBJ: begin
        sel_pix    = '{x: bus.obj_x, y: bus.obj_y, colour: bus.obj_colour};
        sel_active = 1'b1;
        sel_done   = bus.obj_done;
      end
      ST_GO: begin
        sel_pix    = '{x: bus.go_x, y: bus.go_y, colour: bus.go_colour};
        sel_active = 1'b1;
        sel_done   = bus.go_done;
      end
      default: begin
        sel_pix    = '0;
        sel_active = 1'b0;
        sel_done   = 1'b0;
      end
    endcase
  end

  // one-cycle pixel register lines up with the clients' ROM read; done cycle never plots
  always_ff @(posedge clock) begin
    if (!resetn) begin
      vga_pix_q  <= '0;
      vga_plot_q <= 1'b0;
    end else begin
      vga_plot_q <= sel_active & ~sel_done & pixel_on_screen(sel_pix, SCREEN_W, SCREEN_H);
      if (sel_active) begin
        vga_pix_q <= sel_pix;
      end
    end
  end

  assign bus.vga_x      = vga_pix_q.x;
  assign bus.vga_y      = vga_pix_q.y;
  assign bus.vga_colour = vga_pix_q.colour;
  assign bus.vga_plot   = vga_plot_q;

endmodule
